// File: rtl/score_pkg.sv
// Shared types for the round sequencer: result codes, FSM state encoding and
// the first-event latch rule applied to each player.
package score_pkg;

    typedef logic [1:0] result_t;

    localparam result_t RES_MISS = 2'd0;
    localparam result_t RES_HIT  = 2'd1;
    localparam result_t RES_NONE = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_CALC,
        S_COOLDOWN,
        S_DONE
    } state_t;

    // Only the first event of a round sticks; a simultaneous hit and miss
    // resolves to a miss.
    function automatic result_t latch_result(input result_t cur,
                                             input logic    hit,
                                             input logic    miss);
        result_t res;
        res = cur;
        if (cur == RES_NONE) begin
            if (miss)
                res = RES_MISS;
            else if (hit)
                res = RES_HIT;
        end
        return res;
    endfunction

endpackage

// File: rtl/round_timer.sv
// Loadable down-counter that stops at zero; used for both the response window
// and the inter-round cooldown.
module round_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load)
            count_d = load_val;
        else if (en && (count_q != '0))
            count_d = count_q - W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/score_round_ctrl.sv
// Round sequencer in front of the two-player score accumulator.
// Optional early window close when both players have answered: SCORE_CTRL_EARLY_CLOSE_EN.
module score_round_ctrl
    import score_pkg::*;
#(
    parameter int ROUND_CYCLES    = 16,
    parameter int COOLDOWN_CYCLES = 4,
    parameter int NUM_ROUNDS      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       p1_hit,
    input  logic       p1_miss,
    input  logic       p2_hit,
    input  logic       p2_miss,
    output logic [1:0] b1,
    output logic [1:0] b2,
    output logic       start_calc,
    output logic [7:0] round_num,
    output logic       busy,
    output logic       game_done
);

    localparam int WIN_W  = (ROUND_CYCLES > 1) ? $clog2(ROUND_CYCLES) : 1;
    localparam int COOL_W = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
    localparam logic [WIN_W-1:0]  WIN_LOAD   = WIN_W'(ROUND_CYCLES - 1);
    localparam logic [COOL_W-1:0] COOL_LOAD  = COOL_W'(COOLDOWN_CYCLES - 1);
    localparam logic [7:0]        LAST_ROUND = 8'(NUM_ROUNDS);

    state_t        state_q, state_d;
    logic [7:0]    round_q, round_d;
    logic          win_load, win_en, win_zero;
    logic          cool_load, cool_en, cool_zero;
    logic          res_clear, b_load;
    logic          early_close;
    logic [1:0]    hit_v, miss_v;
    result_t [1:0] res_cap;
    result_t [1:0] b_cur;

    assign hit_v  = {p2_hit, p1_hit};
    assign miss_v = {p2_miss, p1_miss};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_player
            result_t res_q, res_d;
            result_t b_q, b_d;

            // Capture view includes this cycle's event so a last-cycle hit still counts.
            assign res_cap[gi] = (state_q == S_COLLECT)
                               ? latch_result(res_q, hit_v[gi], miss_v[gi])
                               : res_q;

            always_comb begin
                res_d = res_clear ? RES_NONE : res_cap[gi];
                b_d   = b_load ? res_cap[gi] : b_q;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    res_q <= RES_NONE;
                    b_q   <= RES_NONE;
                end else begin
                    res_q <= res_d;
                    b_q   <= b_d;
                end
            end

            assign b_cur[gi] = b_q;
        end
    endgenerate

`ifdef SCORE_CTRL_EARLY_CLOSE_EN
    assign early_close = (res_cap[0] != RES_NONE) && (res_cap[1] != RES_NONE);
`else
    assign early_close = 1'b0;
`endif

    round_timer #(.W(WIN_W)) u_win_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (win_load),
        .load_val (WIN_LOAD),
        .en       (win_en),
        .zero     (win_zero)
    );

    round_timer #(.W(COOL_W)) u_cool_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (cool_load),
        .load_val (COOL_LOAD),
        .en       (cool_en),
        .zero     (cool_zero)
    );

    always_comb begin
        state_d    = state_q;
        round_d    = round_q;
        win_load   = 1'b0;
        win_en     = 1'b0;
        cool_load  = 1'b0;
        cool_en    = 1'b0;
        res_clear  = 1'b0;
        b_load     = 1'b0;
        start_calc = 1'b0;
        game_done  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    round_d   = '0;
                    win_load  = 1'b1;
                    res_clear = 1'b1;
                    state_d   = S_COLLECT;
                end
            end
            S_COLLECT: begin
                win_en = 1'b1;
                // Codes and round count update on entry so they are valid during the strobe.
                if (win_zero || early_close) begin
                    b_load  = 1'b1;
                    round_d = round_q + 8'd1;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                start_calc = 1'b1;
                cool_load  = 1'b1;
                state_d    = (round_q == LAST_ROUND) ? S_DONE : S_COOLDOWN;
            end
            S_COOLDOWN: begin
                cool_en = 1'b1;
                if (cool_zero) begin
                    win_load  = 1'b1;
                    res_clear = 1'b1;
                    state_d   = S_COLLECT;
                end
            end
            S_DONE: begin
                game_done = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d    = S_IDLE;
            start_calc = 1'b0;
            b_load     = 1'b0;
            round_d    = round_q;
            win_load   = 1'b0;
            cool_load  = 1'b0;
            res_clear  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
        end
    end

    assign b1        = b_cur[0];
    assign b2        = b_cur[1];
    assign round_num = round_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_score_round_ctrl.sv
// Scoreboard bench for score_round_ctrl with ROUND_CYCLES=4, COOLDOWN_CYCLES=2, NUM_ROUNDS=2.
module tb_score_round_ctrl;

`ifdef SCORE_CTRL_EARLY_CLOSE_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    localparam int GAME_LEN = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       p1_hit = 1'b0, p1_miss = 1'b0, p2_hit = 1'b0, p2_miss = 1'b0;
    logic [1:0] b1, b2;
    logic       start_calc;
    logic [7:0] round_num;
    logic       busy;
    logic       game_done;

    typedef struct {
        int         cyc;
        logic [1:0] b1;
        logic [1:0] b2;
        logic [7:0] rn;
    } exp_t;

    exp_t sb_q[$];
    int   ev[GAME_LEN];
    int   n_checks = 0;
    int   n_errors = 0;

    score_round_ctrl #(
        .ROUND_CYCLES    (4),
        .COOLDOWN_CYCLES (2),
        .NUM_ROUNDS      (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .p1_hit     (p1_hit),
        .p1_miss    (p1_miss),
        .p2_hit     (p2_hit),
        .p2_miss    (p2_miss),
        .b1         (b1),
        .b2         (b2),
        .start_calc (start_calc),
        .round_num  (round_num),
        .busy       (busy),
        .game_done  (game_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_events();
        for (int i = 0; i < GAME_LEN; i++) ev[i] = 0;
    endtask

    task automatic push_exp(input int cyc, input logic [1:0] e1, input logic [1:0] e2,
                            input logic [7:0] rn);
        exp_t e;
        e.cyc = cyc; e.b1 = e1; e.b2 = e2; e.rn = rn;
        sb_q.push_back(e);
    endtask

    // ev bits: 0 p1_hit, 1 p1_miss, 2 p2_hit, 3 p2_miss. Cycle 0 drives start.
    task automatic run_game(input string name, input int abort_c, input int done_c,
                            input int idle_c);
        int   done_seen;
        exp_t e;
        done_seen = 0;
        for (int c = 0; c < GAME_LEN; c++) begin
            start   = (c == 0);
            abort   = (c == abort_c);
            p1_hit  = ev[c][0];
            p1_miss = ev[c][1];
            p2_hit  = ev[c][2];
            p2_miss = ev[c][3];
            #3;
            if (start_calc) begin
                if (sb_q.size() == 0) begin
                    check({name, "_unexpected_calc_cycle"}, c, 32'hFFFF_FFFF);
                end else begin
                    e = sb_q.pop_front();
                    check({name, "_calc_cycle"}, c, e.cyc);
                    check({name, "_b1"}, 32'(b1), 32'(e.b1));
                    check({name, "_b2"}, 32'(b2), 32'(e.b2));
                    check({name, "_round_num"}, 32'(round_num), 32'(e.rn));
                end
            end
            if (game_done) begin
                done_seen++;
                check({name, "_done_cycle"}, c, done_c);
            end
            if (c == idle_c - 1) check({name, "_busy_before_idle"}, 32'(busy), 1);
            if (c == idle_c)     check({name, "_busy_idle"}, 32'(busy), 0);
            tick();
        end
        start = 0; abort = 0;
        p1_hit = 0; p1_miss = 0; p2_hit = 0; p2_miss = 0;
        check({name, "_pending_calcs"}, sb_q.size(), 0);
        check({name, "_done_count"}, done_seen, (done_c >= 0) ? 1 : 0);
        sb_q.delete();
    endtask

    initial begin
        // Reset values
        repeat (3) tick();
        check("rst_b1", 32'(b1), 2);
        check("rst_b2", 32'(b2), 2);
        check("rst_start_calc", 32'(start_calc), 0);
        check("rst_round_num", 32'(round_num), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_game_done", 32'(game_done), 0);
        rst = 0;
        tick();

        // A: p1 hit at 2, p2 miss at 3; empty second round
        clear_events();
        ev[2] = 1; ev[3] = 8;
        if (EARLY) begin
            push_exp(4, 2'd1, 2'd0, 8'd1);
            push_exp(11, 2'd2, 2'd2, 8'd2);
            run_game("A", -1, 12, 13);
        end else begin
            push_exp(5, 2'd1, 2'd0, 8'd1);
            push_exp(12, 2'd2, 2'd2, 8'd2);
            run_game("A", -1, 13, 14);
        end
        check("A_round_num_hold", 32'(round_num), 2);

        // B: silent round 1; round 2 p1 miss then hit, p2 hit+miss together
        clear_events();
        ev[8] = 2; ev[9] = 1; ev[10] = 4 | 8;
        push_exp(5, 2'd2, 2'd2, 8'd1);
        if (EARLY) begin
            push_exp(11, 2'd0, 2'd0, 8'd2);
            run_game("B", -1, 12, 13);
        end else begin
            push_exp(12, 2'd0, 2'd0, 8'd2);
            run_game("B", -1, 13, 14);
        end
        check("B_b1_hold_idle", 32'(b1), 0);
        check("B_b2_hold_idle", 32'(b2), 0);

        // Reset in the middle of a game
        start = 1; tick(); start = 0;
        tick(); tick();
        check("midrst_busy_pre", 32'(busy), 1);
        rst = 1; tick();
        check("midrst_busy", 32'(busy), 0);
        check("midrst_b1", 32'(b1), 2);
        check("midrst_start_calc", 32'(start_calc), 0);
        check("midrst_round_num", 32'(round_num), 0);
        rst = 0; tick();

        // C: p2 hit on the last window cycle; events in cooldown are dropped
        clear_events();
        ev[4] = 4; ev[6] = 1; ev[7] = 8;
        push_exp(5, 2'd2, 2'd1, 8'd1);
        push_exp(12, 2'd2, 2'd2, 8'd2);
        run_game("C", -1, 13, 14);

        // D: abort during the strobe cycle
        clear_events();
        ev[1] = 1;
        run_game("D", 5, -1, 6);
        check("D_round_num", 32'(round_num), 1);
        check("D_busy", 32'(busy), 0);

        // E: both players hit at cycle 1
        clear_events();
        ev[1] = 1 | 4;
        if (EARLY) begin
            push_exp(2, 2'd1, 2'd1, 8'd1);
            push_exp(9, 2'd2, 2'd2, 8'd2);
            run_game("E", -1, 10, 11);
        end else begin
            push_exp(5, 2'd1, 2'd1, 8'd1);
            push_exp(12, 2'd2, 2'd2, 8'd2);
            run_game("E", -1, 13, 14);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
